// File: rtl/snake_pkg.sv
// Shared encodings and widths for the snake step scheduler.
// Pure declarations: no latency, no flow control.
package snake_pkg;

  localparam int CNT_W_DEF = 10;
  localparam int LVL_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

endpackage

// File: rtl/snake_step_scheduler_if.sv
// Control/step-handshake bundle between the scheduler and the snake datapath.
// master = scheduler (owns step_req and status), slave = datapath/game controls.
interface snake_step_scheduler_if #(
  parameter int CNT_W = snake_pkg::CNT_W_DEF
);
  import snake_pkg::*;

  logic             tick_en;
  logic             start;
  logic             pause;
  logic             collision;
  logic             food_eaten;
  logic             step_ack;
  logic             step_req;
  logic             step_overrun;
  state_t           state;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] count;
  logic             game_over;

  modport master (
    input  tick_en, start, pause, collision, food_eaten, step_ack,
    output step_req, step_overrun, state, level, period, count, game_over
  );

  modport slave (
    output tick_en, start, pause, collision, food_eaten, step_ack,
    input  step_req, step_overrun, state, level, period, count, game_over
  );

endinterface

// File: rtl/step_period_counter.sv
// Max-compare tick counter: counts en strobes 0..max, wrap is a combinational pulse on the max strobe.
// Count updates one cycle after en; clear dominates en; no backpressure.
module step_period_counter #(
  parameter int CNT_W = 10
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] max,
  input  logic             en,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  assign wrap = en && !clear && (count == max);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || wrap) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/snake_step_scheduler.sv
// Game-speed controller: game FSM, per-period step request over req/ack, food-driven speed levels.
// step_req rises the cycle after a wrap and is held until acked; an unacked wrap pulses step_overrun.
module snake_step_scheduler
  import snake_pkg::*;
#(
  parameter int CNT_W           = CNT_W_DEF,
  parameter int LEVELS          = 4,
  parameter int BASE_PERIOD     = 999,
  parameter int PERIOD_DEC      = 200,
  parameter int FOODS_PER_LEVEL = 4
) (
  input logic                    clock,
  input logic                    reset_n,
  snake_step_scheduler_if.master bus
);

  localparam int FOOD_W = $clog2(FOODS_PER_LEVEL + 1);

  if ((BASE_PERIOD - (LEVELS - 1) * PERIOD_DEC) < 1 || BASE_PERIOD >= (2 ** CNT_W) ||
      LEVELS > (2 ** LVL_W) || LEVELS < 1 || FOODS_PER_LEVEL < 1) begin : g_bad_cfg
    $error("snake_step_scheduler: inconsistent period/level parameters");
  end

  state_t            st, st_nxt;
  logic [LVL_W-1:0]  level_q;
  logic [FOOD_W-1:0] food_cnt;
  logic [CNT_W-1:0]  period_q;
  logic [CNT_W-1:0]  period_tgt;
  logic [CNT_W-1:0]  cnt;
  logic              step_req_q, step_ovr_q;
  logic              req_nxt, ovr_nxt;
  logic              live, to_over, restart, hold_evt;
  logic              tick_ok, food_ok, acked, wrap;

  // One event per cycle: a higher-priority event swallows that cycle's tick and food.
  assign live     = (st == ST_RUN) || (st == ST_PAUSE);
  assign to_over  = bus.collision && live;
  assign restart  = bus.start && !to_over;
  assign hold_evt = bus.collision || bus.start || bus.pause;
  assign tick_ok  = (st == ST_RUN) && bus.tick_en && !hold_evt;
  assign food_ok  = live && bus.food_eaten && !hold_evt;
  assign acked    = step_req_q && bus.step_ack;

  assign period_tgt = CNT_W'(BASE_PERIOD) - CNT_W'(level_q) * CNT_W'(PERIOD_DEC);

  step_period_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .max     (period_q),
    .en      (tick_ok),
    .clear   (restart),
    .count   (cnt),
    .wrap    (wrap)
  );

  always_comb begin
    st_nxt  = st;
    req_nxt = step_req_q && !acked;
    ovr_nxt = 1'b0;
    if (to_over) begin
      st_nxt = ST_OVER;
    end else if (restart) begin
      st_nxt = ST_RUN;
    end else if (bus.pause && st == ST_RUN) begin
      st_nxt = ST_PAUSE;
    end else if (bus.pause && st == ST_PAUSE) begin
      st_nxt = ST_RUN;
    end
    // A new game or game over discards any pending step.
    if (to_over || restart) begin
      req_nxt = 1'b0;
    end else if (wrap) begin
      ovr_nxt = req_nxt;
      req_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st <= ST_IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      step_req_q <= 1'b0;
      step_ovr_q <= 1'b0;
      level_q    <= '0;
      food_cnt   <= '0;
      period_q   <= CNT_W'(BASE_PERIOD);
    end else begin
      step_req_q <= req_nxt;
      step_ovr_q <= ovr_nxt;
      if (restart) begin
        level_q  <= '0;
        food_cnt <= '0;
        period_q <= CNT_W'(BASE_PERIOD);
      end else if (!to_over) begin
        // Period follows the level only at a wrap so count never passes it.
        if (wrap) begin
          period_q <= period_tgt;
        end
        if (food_ok) begin
          if (food_cnt == FOOD_W'(FOODS_PER_LEVEL - 1)) begin
            food_cnt <= '0;
            if (level_q != LVL_W'(LEVELS - 1)) begin
              level_q <= level_q + 1'b1;
            end
          end else begin
            food_cnt <= food_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign bus.step_req     = step_req_q;
  assign bus.step_overrun = step_ovr_q;
  assign bus.state        = st;
  assign bus.level        = level_q;
  assign bus.period       = period_q;
  assign bus.count        = cnt;
  assign bus.game_over    = (st == ST_OVER);

endmodule

// File: tb/tb_snake_step_scheduler.sv
// Bench for snake_step_scheduler: vector table, directed multi-cycle sequences, random run vs game-rule model.
module tb_snake_step_scheduler;

  localparam int BASE = 999;
  localparam int DEC  = 200;
  localparam int LVLS = 4;
  localparam int FPL  = 4;

  localparam logic [5:0] EV_T = 6'h01;
  localparam logic [5:0] EV_S = 6'h02;
  localparam logic [5:0] EV_P = 6'h04;
  localparam logic [5:0] EV_C = 6'h08;
  localparam logic [5:0] EV_F = 6'h10;
  localparam logic [5:0] EV_A = 6'h20;

  logic clock;
  logic reset_n;
  int   n_chk;
  int   n_fail;

  snake_step_scheduler_if #(.CNT_W(10)) bus ();

  snake_step_scheduler dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Game-rule reference: 0 idle, 1 run, 2 pause, 3 over
  int m_st, m_count, m_level, m_food, m_period, m_req, m_ovr;

  task automatic model_reset();
    m_st = 0; m_count = 0; m_level = 0; m_food = 0;
    m_period = BASE; m_req = 0; m_ovr = 0;
  endtask

  task automatic model_edge(input logic [5:0] ev);
    bit live, over, rst, busy, tick, food, wrapped;
    live    = (m_st == 1) || (m_st == 2);
    over    = ev[3] && live;
    rst     = ev[1] && !over;
    busy    = ev[3] || ev[1] || ev[2];
    tick    = ev[0] && (m_st == 1) && !busy;
    food    = ev[4] && live && !busy;
    wrapped = tick && (m_count == m_period);
    m_ovr   = 0;
    if (over) begin
      m_st = 3; m_req = 0;
    end else if (rst) begin
      m_st = 1; m_count = 0; m_level = 0; m_food = 0; m_period = BASE; m_req = 0;
    end else begin
      if (ev[2] && live) m_st = (m_st == 1) ? 2 : 1;
      if (ev[5] && m_req == 1) m_req = 0;
      if (wrapped) begin
        if (m_req == 1) m_ovr = 1;
        m_req    = 1;
        m_count  = 0;
        m_period = BASE - m_level * DEC;
      end else if (tick) begin
        m_count = m_count + 1;
      end
      if (food) begin
        m_food = m_food + 1;
        if (m_food == FPL) begin
          m_food = 0;
          if (m_level < LVLS - 1) m_level = m_level + 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("mdl_state", 32'(bus.state), m_st);
    chk("mdl_count", 32'(bus.count), m_count);
    chk("mdl_level", 32'(bus.level), m_level);
    chk("mdl_period", 32'(bus.period), m_period);
    chk("mdl_step_req", 32'(bus.step_req), m_req);
    chk("mdl_overrun", 32'(bus.step_overrun), m_ovr);
    chk("mdl_game_over", 32'(bus.game_over), (m_st == 3) ? 1 : 0);
  endtask

  task automatic step(input logic [5:0] ev);
    bus.tick_en    = ev[0];
    bus.start      = ev[1];
    bus.pause      = ev[2];
    bus.collision  = ev[3];
    bus.food_eaten = ev[4];
    bus.step_ack   = ev[5];
    @(posedge clock);
    if (reset_n) model_edge(ev);
    #1;
    bus.tick_en = 0; bus.start = 0; bus.pause = 0;
    bus.collision = 0; bus.food_eaten = 0; bus.step_ack = 0;
    check_model();
  endtask

  task automatic tick_until_req(input int bound, input string name);
    int n;
    n = 0;
    while (!bus.step_req && n < bound) begin
      step(EV_T);
      n++;
    end
    chk(name, 32'(bus.step_req), 1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, 32'(bus.state), 0);
    chk({tag, "_count"}, 32'(bus.count), 0);
    chk({tag, "_level"}, 32'(bus.level), 0);
    chk({tag, "_period"}, 32'(bus.period), BASE);
    chk({tag, "_req"}, 32'(bus.step_req), 0);
    chk({tag, "_ovr"}, 32'(bus.step_overrun), 0);
    chk({tag, "_go"}, 32'(bus.game_over), 0);
  endtask

  typedef struct {
    logic [5:0] ev;
    int st, cnt, go, req, lvl;
  } vec_t;

  vec_t tbl[21];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ovr, n_req_low;
    logic [5:0] ev;
    n_chk = 0; n_fail = 0;
    bus.tick_en = 0; bus.start = 0; bus.pause = 0;
    bus.collision = 0; bus.food_eaten = 0; bus.step_ack = 0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #20;
    model_reset();
    check_reset_values("por");
    @(negedge clock) reset_n = 1'b1;

    // Table: {events, state, count, game_over, step_req, level}
    tbl[0]  = '{6'h00,        0, 0, 0, 0, 0};
    tbl[1]  = '{EV_T | EV_A,  0, 0, 0, 0, 0};
    tbl[2]  = '{EV_P,         0, 0, 0, 0, 0};
    tbl[3]  = '{EV_C,         0, 0, 0, 0, 0};
    tbl[4]  = '{EV_S,         1, 0, 0, 0, 0};
    tbl[5]  = '{EV_T,         1, 1, 0, 0, 0};
    tbl[6]  = '{EV_T,         1, 2, 0, 0, 0};
    tbl[7]  = '{EV_P,         2, 2, 0, 0, 0};
    tbl[8]  = '{EV_T,         2, 2, 0, 0, 0};
    tbl[9]  = '{EV_F,         2, 2, 0, 0, 0};
    tbl[10] = '{EV_P | EV_T,  1, 2, 0, 0, 0};
    tbl[11] = '{EV_T,         1, 3, 0, 0, 0};
    tbl[12] = '{EV_F | EV_T,  1, 4, 0, 0, 0};
    tbl[13] = '{EV_F,         1, 4, 0, 0, 0};
    tbl[14] = '{EV_F,         1, 4, 0, 0, 1};
    tbl[15] = '{EV_P | EV_T,  2, 4, 0, 0, 1};
    tbl[16] = '{EV_P,         1, 4, 0, 0, 1};
    tbl[17] = '{EV_C | EV_S | EV_P | EV_T, 3, 4, 1, 0, 1};
    tbl[18] = '{EV_T | EV_P | EV_F,        3, 4, 1, 0, 1};
    tbl[19] = '{EV_S,         1, 0, 0, 0, 0};
    tbl[20] = '{EV_T,         1, 1, 0, 0, 0};
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].ev);
      chk($sformatf("tbl%0d_state", i), 32'(bus.state), tbl[i].st);
      chk($sformatf("tbl%0d_count", i), 32'(bus.count), tbl[i].cnt);
      chk($sformatf("tbl%0d_go", i), 32'(bus.game_over), tbl[i].go);
      chk($sformatf("tbl%0d_req", i), 32'(bus.step_req), tbl[i].req);
      chk($sformatf("tbl%0d_level", i), 32'(bus.level), tbl[i].lvl);
    end

    // First period: request exactly one cycle after the 1000th tick
    step(EV_S);
    for (int i = 0; i < 999; i++) step(EV_T);
    chk("p1_count_999", 32'(bus.count), 999);
    chk("p1_req_before", 32'(bus.step_req), 0);
    step(EV_T);
    chk("p1_req_rise", 32'(bus.step_req), 1);
    chk("p1_count_wrap", 32'(bus.count), 0);
    step(6'h00);
    step(6'h00);
    chk("p1_req_held", 32'(bus.step_req), 1);
    step(EV_A);
    chk("p1_req_fall", 32'(bus.step_req), 0);

    // Two wraps with no ack: one held request, one overrun pulse
    n_ovr = 0; n_req_low = 0;
    for (int i = 1; i <= 2000; i++) begin
      step(EV_T);
      n_ovr += int'(bus.step_overrun);
      if (i >= 1000 && !bus.step_req) n_req_low++;
    end
    chk("ovr_pulse_last", 32'(bus.step_overrun), 1);
    chk("ovr_pulse_count", n_ovr, 1);
    chk("ovr_req_held", n_req_low, 0);
    step(EV_A);
    chk("ovr_ack_req", 32'(bus.step_req), 0);
    chk("ovr_one_cycle", 32'(bus.step_overrun), 0);

    // Speed levels
    for (int i = 0; i < 4; i++) step(EV_F);
    chk("lvl1_level", 32'(bus.level), 1);
    chk("lvl1_period_hold", 32'(bus.period), 999);
    tick_until_req(1100, "lvl1_wrap");
    chk("lvl1_period", 32'(bus.period), 799);
    step(EV_A);
    for (int i = 0; i < 12; i++) step(EV_F);
    chk("lvl3_level", 32'(bus.level), 3);
    chk("lvl3_period_hold", 32'(bus.period), 799);
    tick_until_req(900, "lvl3_wrap");
    chk("lvl3_period", 32'(bus.period), 399);
    step(EV_A);
    for (int i = 0; i < 4; i++) step(EV_F);
    chk("lvl_saturate", 32'(bus.level), 3);

    // Pause holds the count across many ticks
    step(EV_S);
    chk("pz_period_restart", 32'(bus.period), 999);
    for (int i = 0; i < 500; i++) step(EV_T);
    chk("pz_count_500", 32'(bus.count), 500);
    step(EV_P);
    for (int i = 0; i < 2000; i++) step(EV_T);
    chk("pz_state", 32'(bus.state), 2);
    chk("pz_count_held", 32'(bus.count), 500);
    step(EV_P);
    chk("pz_resume_state", 32'(bus.state), 1);
    step(EV_T);
    chk("pz_count_501", 32'(bus.count), 501);

    // Asynchronous reset mid-run with a pending request
    for (int i = 0; i < 4; i++) step(EV_F);
    tick_until_req(600, "ar_req_pending");
    chk("ar_level_pre", 32'(bus.level), 1);
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("ar");
    @(negedge clock) reset_n = 1'b1;

    // Collision beats start and pause; restart afterwards
    step(EV_S);
    for (int i = 0; i < 4; i++) step(EV_F);
    tick_until_req(1100, "co_req_pending");
    for (int i = 0; i < 5; i++) step(EV_T);
    step(EV_C | EV_P | EV_S | EV_T);
    chk("co_state", 32'(bus.state), 3);
    chk("co_game_over", 32'(bus.game_over), 1);
    chk("co_req_drop", 32'(bus.step_req), 0);
    chk("co_count_frozen", 32'(bus.count), 5);
    step(EV_T | EV_F | EV_A);
    chk("co_over_hold", 32'(bus.count), 5);
    step(EV_S);
    chk("co_restart_state", 32'(bus.state), 1);
    chk("co_restart_level", 32'(bus.level), 0);
    chk("co_restart_count", 32'(bus.count), 0);
    chk("co_restart_period", 32'(bus.period), 999);
    chk("co_restart_go", 32'(bus.game_over), 0);

    // Random play against the model
    for (int i = 0; i < 20000; i++) begin
      ev = 6'h00;
      ev[0] = ($urandom_range(3) != 0);
      ev[1] = ($urandom_range(1999) == 0);
      ev[2] = ($urandom_range(299) == 0);
      ev[3] = ($urandom_range(2999) == 0);
      ev[4] = ($urandom_range(49) == 0);
      ev[5] = ($urandom_range(7) == 0);
      if (m_st == 3 && $urandom_range(99) == 0) ev[1] = 1'b1;
      step(ev);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
